uart_serdes: RTL and testbench

- 8N1 UART transmitter/receiver. Sits directly downstream of the execute-stage input_output unit, which drives en and data_send and consumes rdy.
- TX serialises one byte per accepted request.
- RX deserialises bytes from rxd and presents them with a one-cycle valid strobe for a future IN instruction path.
- Single clock domain. rxd is asynchronous and synchronised internally.

---
 rtl/uart_serdes.sv | 209 ++++++++++++++++++++
 tb/tb_uart_serdes.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_serdes.sv
// rtl/uart_serdes.sv - 8N1 UART transmitter/receiver
// TX accepts one byte per rising edge of en; RX presents bytes with a one-cycle valid strobe.
module uart_serdes #(
  parameter int CLKS_PER_BIT = 434,
  parameter int CNT_W        = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [7:0] data_send,
  output logic       rdy,
  output logic       txd,
  input  logic       rxd,
  output logic [7:0] data_recv,
  output logic       recv_valid,
  output logic       frame_err
);

  localparam logic [CNT_W-1:0] LP_BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] LP_HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT_HIGH
  } rx_state_t;

  tx_state_t        r_tx_state;
  logic             r_en_q;
  logic [CNT_W-1:0] r_tx_cnt;
  logic [2:0]       r_tx_bit;
  logic [7:0]       r_tx_shift;
  logic             r_txd;
  logic             r_rdy;

  rx_state_t        r_rx_state;
  logic             r_rx_s1;
  logic             r_rxs;
  logic [CNT_W-1:0] r_rx_cnt;
  logic [2:0]       r_rx_bit;
  logic [7:0]       r_rx_shift;
  logic [7:0]       r_data_recv;
  logic             r_recv_valid;
  logic             r_frame_err;

  logic w_accept;
  logic w_tx_bit_end;
  logic w_rx_bit_end;
  logic w_rx_half_end;

  // execute holds en for several cycles, so only its rising edge requests a frame
  assign w_accept      = en & ~r_en_q & r_rdy;
  assign w_tx_bit_end  = (r_tx_cnt == LP_BIT_LAST);
  assign w_rx_bit_end  = (r_rx_cnt == LP_BIT_LAST);
  assign w_rx_half_end = (r_rx_cnt == LP_HALF_LAST);

  assign rdy        = r_rdy;
  assign txd        = r_txd;
  assign data_recv  = r_data_recv;
  assign recv_valid = r_recv_valid;
  assign frame_err  = r_frame_err;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tx_state <= TX_IDLE;
      r_en_q     <= 1'b0;
      r_tx_cnt   <= '0;
      r_tx_bit   <= 3'd0;
      r_tx_shift <= 8'h00;
      r_txd      <= 1'b1;
      r_rdy      <= 1'b1;
    end else begin
      r_en_q <= en;
      case (r_tx_state)
        TX_IDLE: begin
          if (w_accept) begin
            r_tx_shift <= data_send;
            r_rdy      <= 1'b0;
            r_txd      <= 1'b0;
            r_tx_cnt   <= '0;
            r_tx_state <= TX_START;
          end
        end
        TX_START: begin
          if (w_tx_bit_end) begin
            r_tx_cnt   <= '0;
            r_tx_bit   <= 3'd0;
            r_txd      <= r_tx_shift[0];
            r_tx_state <= TX_DATA;
          end else begin
            r_tx_cnt <= r_tx_cnt + 1'b1;
          end
        end
        TX_DATA: begin
          if (w_tx_bit_end) begin
            r_tx_cnt <= '0;
            if (r_tx_bit == 3'd7) begin
              r_txd      <= 1'b1;
              r_tx_state <= TX_STOP;
            end else begin
              r_tx_shift <= {1'b0, r_tx_shift[7:1]};
              r_txd      <= r_tx_shift[1];
              r_tx_bit   <= r_tx_bit + 3'd1;
            end
          end else begin
            r_tx_cnt <= r_tx_cnt + 1'b1;
          end
        end
        TX_STOP: begin
          if (w_tx_bit_end) begin
            r_tx_cnt   <= '0;
            r_rdy      <= 1'b1;
            r_tx_state <= TX_IDLE;
          end else begin
            r_tx_cnt <= r_tx_cnt + 1'b1;
          end
        end
        default: begin
          r_txd      <= 1'b1;
          r_rdy      <= 1'b1;
          r_tx_state <= TX_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rx_state   <= RX_IDLE;
      r_rx_s1      <= 1'b1;
      r_rxs        <= 1'b1;
      r_rx_cnt     <= '0;
      r_rx_bit     <= 3'd0;
      r_rx_shift   <= 8'h00;
      r_data_recv  <= 8'h00;
      r_recv_valid <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_rx_s1      <= rxd;
      r_rxs        <= r_rx_s1;
      r_recv_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      case (r_rx_state)
        RX_IDLE: begin
          if (!r_rxs) begin
            r_rx_cnt   <= '0;
            r_rx_state <= RX_START;
          end
        end
        RX_START: begin
          // a start bit that is gone by mid-bit is treated as line noise
          if (w_rx_half_end) begin
            r_rx_cnt   <= '0;
            r_rx_bit   <= 3'd0;
            r_rx_state <= r_rxs ? RX_IDLE : RX_DATA;
          end else begin
            r_rx_cnt <= r_rx_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (w_rx_bit_end) begin
            r_rx_cnt   <= '0;
            r_rx_shift <= {r_rxs, r_rx_shift[7:1]};
            if (r_rx_bit == 3'd7) begin
              r_rx_state <= RX_STOP;
            end else begin
              r_rx_bit <= r_rx_bit + 3'd1;
            end
          end else begin
            r_rx_cnt <= r_rx_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (w_rx_bit_end) begin
            r_rx_cnt <= '0;
            if (r_rxs) begin
              r_data_recv  <= r_rx_shift;
              r_recv_valid <= 1'b1;
              r_rx_state   <= RX_IDLE;
            end else begin
              r_frame_err <= 1'b1;
              r_rx_state  <= RX_WAIT_HIGH;
            end
          end else begin
            r_rx_cnt <= r_rx_cnt + 1'b1;
          end
        end
        RX_WAIT_HIGH: begin
          if (r_rxs) begin
            r_rx_state <= RX_IDLE;
          end
        end
        default: begin
          r_rx_state <= RX_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_serdes.sv
// tb/tb_uart_serdes.sv - randomized and directed bench for uart_serdes against a frame-level model
module tb_uart_serdes;

  localparam int CPB = 8;
  localparam int LAT = 3 + CPB / 2 + 9 * CPB;

  typedef struct {
    logic [7:0] data;
    bit         err;
    int         t;
  } rx_exp_t;

  logic       clk;
  logic       reset;
  logic       en;
  logic [7:0] data_send;
  logic       rdy;
  logic       txd;
  logic       rxd;
  logic [7:0] data_recv;
  logic       recv_valid;
  logic       frame_err;

  logic       rxd_drv;
  logic       loopback;
  int         cyc = 0;
  int         tests = 0;
  int         fails = 0;
  int         n_valid = 0;
  int         n_ferr = 0;
  logic [7:0] rx_log[$];
  rx_exp_t    exp_q[$];

  logic       m_en_q;
  int         m_left;
  int         m_t;
  logic [9:0] m_frame;
  logic       m_rdy;
  logic       m_txd;
  logic [7:0] m_last;

  assign rxd = loopback ? txd : rxd_drv;

  uart_serdes #(.CLKS_PER_BIT(CPB), .CNT_W(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .data_send  (data_send),
    .rdy        (rdy),
    .txd        (txd),
    .rxd        (rxd),
    .data_recv  (data_recv),
    .recv_valid (recv_valid),
    .frame_err  (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    tests++;
    if (act !== exp_v) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  // Frame-level TX model: a busy countdown plus the 10-bit line image of the accepted byte
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_en_q  <= 1'b0;
      m_left  <= 0;
      m_t     <= 0;
      m_frame <= 10'h3FF;
    end else begin
      m_en_q <= en;
      if (m_left == 0) begin
        if (en && !m_en_q) begin
          m_frame <= {1'b1, data_send, 1'b0};
          m_left  <= 10 * CPB;
          m_t     <= 0;
        end
      end else begin
        m_left <= m_left - 1;
        m_t    <= m_t + 1;
      end
    end
  end

  always_comb begin
    m_rdy = (m_left == 0);
    m_txd = 1'b1;
    if (!m_rdy) m_txd = m_frame[m_t / CPB];
  end

  initial begin
    rx_exp_t e;
    int lat;
    m_last = 8'h00;
    forever begin
      @(negedge clk);
      if (!reset) begin
        m_last = 8'h00;
      end else begin
        chk("txd", {31'd0, txd}, {31'd0, m_txd});
        chk("rdy", {31'd0, rdy}, {31'd0, m_rdy});
        if (recv_valid) begin
          n_valid++;
          rx_log.push_back(data_recv);
        end
        if (frame_err) n_ferr++;
        if (recv_valid && frame_err) chk("valid_and_ferr_together", 1, 0);
        if (recv_valid || frame_err) begin
          if (exp_q.size() == 0) begin
            chk("rx_unexpected_pulse", {31'd0, recv_valid}, {31'd0, 1'b0});
          end else begin
            e = exp_q.pop_front();
            lat = cyc - e.t;
            chk("rx_kind_ferr", {31'd0, frame_err}, {31'd0, e.err});
            chk("rx_latency_in_window", {31'd0, (lat >= LAT - 1 && lat <= LAT + 1)}, 1);
            if (!e.err) begin
              m_last = e.data;
              chk("rx_data", {24'd0, data_recv}, {24'd0, e.data});
            end
          end
        end else if (exp_q.size() > 0 && cyc > exp_q[0].t + LAT + 1) begin
          e = exp_q.pop_front();
          chk("rx_timeout_no_pulse", 0, 1);
        end
        chk("data_recv_hold", {24'd0, data_recv}, {24'd0, m_last});
      end
    end
  end

  task automatic send_tx(input logic [7:0] b, input bit push);
    int k = 0;
    while (!rdy && k < 1000) begin
      @(negedge clk);
      k++;
    end
    chk("send_rdy_wait", {31'd0, rdy}, 1);
    data_send = b;
    en = 1'b1;
    if (push) exp_q.push_back('{b, 1'b0, cyc + 1});
    @(negedge clk);
    en = 1'b0;
  endtask

  task automatic drive_frame(input logic [7:0] b, input bit stop);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    exp_q.push_back('{b, !stop, cyc});
    for (int i = 0; i < 10; i++) begin
      rxd_drv = fr[i];
      repeat (CPB) @(negedge clk);
    end
  endtask

  initial begin
    int n;
    int n0;
    int f0;
    logic samp[200];
    bit a5_seq[10];
    logic [7:0] lb[3];
    logic [7:0] rb;
    a5_seq = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    lb = '{8'h00, 8'hFF, 8'h5A};
    for (int i = 0; i < 200; i++) samp[i] = 1'b0;
    reset = 1'b0; en = 1'b0; data_send = 8'h00; rxd_drv = 1'b1; loopback = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_txd", {31'd0, txd}, 1);
    chk("rst_rdy", {31'd0, rdy}, 1);
    chk("rst_data_recv", {24'd0, data_recv}, 0);
    chk("rst_recv_valid", {31'd0, recv_valid}, 0);
    chk("rst_frame_err", {31'd0, frame_err}, 0);
    #2 reset = 1'b1;
    repeat (4) @(negedge clk);

    data_send = 8'hA5; en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    n = 0;
    while (rdy == 1'b0 && n < 200) begin
      samp[n] = txd;
      n++;
      @(negedge clk);
    end
    chk("a5_rdy_low_cycles", n, 80);
    for (int k = 0; k < 10; k++) chk("a5_txd_bit", {31'd0, samp[4 + 8 * k]}, {31'd0, a5_seq[k]});
    repeat (10) @(negedge clk);

    data_send = 8'h3C; en = 1'b1; n = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!rdy) n++;
    end
    chk("hold_en_one_frame", n, 80);
    chk("hold_en_rdy_after", {31'd0, rdy}, 1);
    en = 1'b0;
    @(negedge clk);
    en = 1'b1;
    @(negedge clk);
    en = 1'b0; n = 0;
    for (int i = 0; i < 150; i++) begin
      if (!rdy) n++;
      if (i == 20) begin data_send = 8'hFF; en = 1'b1; end
      if (i == 21) en = 1'b0;
      @(negedge clk);
    end
    chk("busy_edge_dropped", n, 80);

    repeat ($urandom_range(3, 9)) @(negedge clk);
    for (int r = 0; r < 4; r++) begin
      data_send = 8'($urandom);
      en = 1'b1;
      repeat ($urandom_range(1, 120)) @(negedge clk);
      en = 1'b0;
      repeat ($urandom_range(1, 40)) @(negedge clk);
    end
    repeat (90) @(negedge clk);

    loopback = 1'b1;
    n0 = rx_log.size();
    f0 = n_ferr;
    for (int k = 0; k < 3; k++) send_tx(lb[k], 1'b1);
    for (int r = 0; r < 3; r++) send_tx(8'($urandom), 1'b1);
    repeat (100) @(negedge clk);
    chk("loop_valid_count", rx_log.size() - n0, 6);
    for (int k = 0; k < 3; k++) begin
      rb = (rx_log.size() > n0 + k) ? rx_log[n0 + k] : 8'hxx;
      chk("loop_data_order", {24'd0, rb}, {24'd0, lb[k]});
    end
    chk("loop_no_ferr", n_ferr, f0);
    loopback = 1'b0;
    repeat (5) @(negedge clk);

    n0 = n_valid; f0 = n_ferr;
    rxd_drv = 1'b0;
    repeat (3) @(negedge clk);
    rxd_drv = 1'b1;
    repeat (30) @(negedge clk);
    chk("glitch_no_valid", n_valid, n0);
    chk("glitch_no_ferr", n_ferr, f0);
    drive_frame(8'h81, 1'b1);
    repeat (10) @(negedge clk);
    chk("after_glitch_81", {24'd0, data_recv}, 8'h81);
    chk("after_glitch_count", n_valid, n0 + 1);

    n0 = n_valid; f0 = n_ferr;
    drive_frame(8'h42, 1'b0);
    repeat (50) @(negedge clk);
    chk("bad_stop_ferr", n_ferr, f0 + 1);
    chk("bad_stop_keeps_data", {24'd0, data_recv}, 8'h81);
    chk("bad_stop_no_valid", n_valid, n0);
    rxd_drv = 1'b1;
    repeat (10) @(negedge clk);
    drive_frame(8'h42, 1'b1);
    repeat (10) @(negedge clk);
    chk("recover_42", {24'd0, data_recv}, 8'h42);
    chk("recover_count", n_valid, n0 + 1);

    for (int r = 0; r < 3; r++) begin
      rb = 8'($urandom);
      drive_frame(rb, 1'b1);
      repeat ($urandom_range(2, 15)) @(negedge clk);
      chk("rand_rx_byte", {24'd0, data_recv}, {24'd0, rb});
    end

    loopback = 1'b1;
    n0 = n_valid; f0 = n_ferr;
    send_tx(8'hC3, 1'b0);
    repeat (43) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_txd", {31'd0, txd}, 1);
    chk("async_rst_rdy", {31'd0, rdy}, 1);
    chk("async_rst_data_recv", {24'd0, data_recv}, 0);
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    @(negedge clk);
    repeat (100) @(negedge clk);
    chk("rst_no_partial_valid", n_valid, n0);
    send_tx(8'hC3, 1'b1);
    repeat (100) @(negedge clk);
    chk("post_rst_c3", {24'd0, data_recv}, 8'hC3);
    chk("post_rst_count", n_valid, n0 + 1);
    chk("post_rst_no_ferr", n_ferr, f0);
    loopback = 1'b0;
    repeat (5) @(negedge clk);
    chk("exp_queue_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
